// File: rtl/can_wb_pkg.sv
// can_wb_master shared types.
// Command/response bundles and FSM states.
`timescale 1ns/1ps
package can_wb_pkg;

  typedef struct packed {
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
  } cmd_t;

  typedef struct packed {
    logic [7:0] dat;
    logic       err;
  } rsp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP,
    S_GAP
  } state_e;

endpackage

// File: rtl/can_wb_if.sv
// Wishbone classic bus between the initiator
// and the CAN controller register port.
`timescale 1ns/1ps
interface can_wb_if;

  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/can_wb_cmd_fifo.sv
// Command FIFO: wrap-bit pointers,
// combinational head on dout.
`timescale 1ns/1ps
module can_wb_cmd_fifo
  import can_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic wb_rst_i,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t        mem_q [DEPTH];
  logic [AW:0] wp_q;
  logic [AW:0] rp_q;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push && !full)  wp_q <= wp_q + 1'b1;
      if (pop  && !empty) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full) mem_q[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/can_wb_master.sv
// Wishbone initiator for the CAN register port:
// one queued command at a time, ack timeout, idle gap.
`timescale 1ns/1ps
module can_wb_master
  import can_wb_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 64,
  parameter int GAP       = 2
) (
  input  logic       clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_we_i,
  input  logic [7:0] cmd_adr_i,
  input  logic [7:0] cmd_dat_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_dat_o,
  output logic       rsp_err_o,
  can_wb_if.master   wb,
  output logic       busy_o
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          cyc_q, cyc_d;
  cmd_t          bus_q, bus_d;
  rsp_t          rsp_q, rsp_d;
  logic          rvld_q, rvld_d;

  cmd_t head;
  logic full, empty, pop, gap_done;

  can_wb_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .wb_rst_i (wb_rst_i),
    .push     (cmd_valid_i && !full),
    .pop      (pop),
    .din      ('{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i}),
    .dout     (head),
    .full     (full),
    .empty    (empty)
  );

  // gap_q counts idle cycles completed since cyc fell
  assign gap_done = (gap_q >= GAP_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    cyc_d   = cyc_q;
    bus_d   = bus_q;
    rsp_d   = rsp_q;
    rvld_d  = rvld_q;
    pop     = 1'b0;
    if (!gap_done) gap_d = gap_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cyc_d   = 1'b1;
          bus_d   = head;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (wb.wb_ack_i) begin
          cyc_d     = 1'b0;
          rsp_d.dat = bus_q.we ? 8'h00 : wb.wb_dat_i;
          rsp_d.err = 1'b0;
          rvld_d    = 1'b1;
          gap_d     = '0;
          state_d   = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          cyc_d     = 1'b0;
          rsp_d.dat = 8'h00;
          rsp_d.err = 1'b1;
          rvld_d    = 1'b1;
          gap_d     = '0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rvld_d  = 1'b0;
          state_d = gap_done ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= GAP_LAST;
      cyc_q   <= 1'b0;
      bus_q   <= '0;
      rsp_q   <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      cyc_q   <= cyc_d;
      bus_q   <= bus_d;
      rsp_q   <= rsp_d;
      rvld_q  <= rvld_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = bus_q.we;
  assign wb.wb_adr_o = bus_q.adr;
  assign wb.wb_dat_o = bus_q.dat;

  assign cmd_ready_o = !full;
  assign rsp_valid_o = rvld_q;
  assign rsp_dat_o   = rsp_q.dat;
  assign rsp_err_o   = rsp_q.err;
  assign busy_o      = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_can_wb_master.sv
// Bench for can_wb_master: scripted and random
// commands against a queue-based reference model.
`timescale 1ns/1ps
module tb_can_wb_master;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 2;

  logic       clk_i = 1'b0;
  logic       wb_rst_i;
  logic       cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [7:0] cmd_adr_i, cmd_dat_i;
  logic       rsp_valid_o, rsp_ready_i;
  logic [7:0] rsp_dat_o;
  logic       rsp_err_o, busy_o;

  can_wb_if wbif();

  can_wb_master #(
    .CMD_DEPTH (DEPTH),
    .TIMEOUT   (TIMEOUT),
    .GAP       (GAP)
  ) dut (
    .clk_i       (clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wb          (wbif),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic we; logic [7:0] adr; logic [7:0] dat;
    int len; int gap;
  } txn_t;
  typedef struct {
    logic we; logic [7:0] adr; logic [7:0] dat;
    int ack_at; logic [7:0] rdata;
  } exp_t;
  typedef struct {
    logic [7:0] dat; logic err;
  } rsp_t;

  int   nvec = 0;
  int   nerr = 0;
  txn_t txn_log[$];
  rsp_t rsp_log[$];
  exp_t exp_q[$];
  int   sl_ack_q[$];
  logic [7:0] sl_dat_q[$];
  int   ready_pct = 100;
  logic inject = 1'b0;
  int   stab_err = 0;

  // Reference model: cycle length and response from the slave's ack slot
  function automatic int m_len(input exp_t e);
    return (e.ack_at >= 1 && e.ack_at <= TIMEOUT) ? e.ack_at : TIMEOUT;
  endfunction

  function automatic rsp_t m_rsp(input exp_t e);
    rsp_t r;
    if (e.ack_at >= 1 && e.ack_at <= TIMEOUT) begin
      r.err = 1'b0;
      r.dat = e.we ? 8'h00 : e.rdata;
    end else begin
      r.err = 1'b1;
      r.dat = 8'h00;
    end
    return r;
  endfunction

  // Slave: acks in the ack_at-th cycle of cyc (0 = never), logs cycles
  initial begin : slave
    int hi, idle, cur_ack;
    logic [7:0] cur_dat;
    txn_t cur;
    hi = 0; idle = 1000; cur_ack = 0; cur_dat = 8'h00;
    cur = '{we: 1'b0, adr: 8'h00, dat: 8'h00, len: 0, gap: 0};
    wbif.wb_ack_i = 1'b0;
    wbif.wb_dat_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (wbif.wb_stb_o !== wbif.wb_cyc_o) stab_err++;
      if (wbif.wb_cyc_o === 1'b1) begin
        if (hi == 0) begin
          cur_ack = (sl_ack_q.size() > 0) ? sl_ack_q.pop_front() : 0;
          cur_dat = (sl_dat_q.size() > 0) ? sl_dat_q.pop_front() : 8'h00;
          cur.we  = wbif.wb_we_o;
          cur.adr = wbif.wb_adr_o;
          cur.dat = wbif.wb_dat_o;
          cur.gap = idle;
          idle    = 0;
        end else if ({wbif.wb_we_o, wbif.wb_adr_o, wbif.wb_dat_o}
                     !== {cur.we, cur.adr, cur.dat}) begin
          stab_err++;
        end
        hi++;
      end else begin
        if (hi != 0) begin
          cur.len = hi;
          txn_log.push_back(cur);
          hi = 0;
        end
        idle++;
      end
      wbif.wb_ack_i = ((wbif.wb_cyc_o === 1'b1) && hi == cur_ack) || inject;
      wbif.wb_dat_i = wbif.wb_ack_i ? cur_dat : 8'($urandom);
    end
  end

  initial begin : consumer
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      rsp_ready_i = ($urandom_range(0, 99) < ready_pct);
      if (rsp_valid_o === 1'b1 && rsp_ready_i && !wb_rst_i)
        rsp_log.push_back('{dat: rsp_dat_o, err: rsp_err_o});
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: run did not finish, want summary");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic we, input logic [7:0] a,
                          input logic [7:0] d, input int ack_at,
                          input logic [7:0] rd);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_we_i = we; cmd_adr_i = a; cmd_dat_i = d;
    while (cmd_ready_o !== 1'b1 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    nvec++;
    if (n >= 500) begin
      nerr++;
      $display("FAIL push_wait ready=%b want 1", cmd_ready_o);
    end
    exp_q.push_back('{we: we, adr: a, dat: d, ack_at: ack_at, rdata: rd});
    sl_ack_q.push_back(ack_at);
    sl_dat_q.push_back(rd);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int want, input int limit);
    int n = 0;
    while (rsp_log.size() < want && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
  endtask

  task automatic clear_logs();
    exp_q.delete(); txn_log.delete(); rsp_log.delete();
    sl_ack_q.delete(); sl_dat_q.delete();
  endtask

  task automatic test_reset();
    logic [29:0] got;
    wb_rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
    cmd_adr_i = 8'h00; cmd_dat_i = 8'h00;
    repeat (3) @(negedge clk_i);
    for (int k = 0; k < 2; k++) begin
      got = {wbif.wb_cyc_o, wbif.wb_stb_o, wbif.wb_we_o, wbif.wb_adr_o,
             wbif.wb_dat_o, rsp_valid_o, rsp_err_o, busy_o, cmd_ready_o};
      nvec++;
      if (got !== 30'h1 || rsp_dat_o !== 8'h00) begin
        nerr++;
        $display("FAIL reset_state[%0d] got=%h/%h want=00000001/00", k, got, rsp_dat_o);
      end
      wb_rst_i = 1'b0;
      @(negedge clk_i);
    end
  endtask

  task automatic test_write();
    exp_t e; txn_t t; rsp_t r, m;
    clear_logs();
    ready_pct = 100;
    push_cmd(1'b1, 8'h04, 8'hA5, 4, 8'h00);
    wait_rsp(1, 300);
    nvec++;
    if (rsp_log.size() != 1 || txn_log.size() != 1) begin
      nerr++;
      $display("FAIL write_count rsp=%0d txn=%0d want 1/1", rsp_log.size(), txn_log.size());
    end else begin
      e = exp_q[0]; t = txn_log[0]; r = rsp_log[0]; m = m_rsp(e);
      nvec++;
      if (t.len != m_len(e)) begin
        nerr++;
        $display("FAIL write_len got=%0d want=%0d", t.len, m_len(e));
      end
      nvec++;
      if ({t.we, t.adr, t.dat} !== {e.we, e.adr, e.dat}) begin
        nerr++;
        $display("FAIL write_bus got=%b/%h/%h want=%b/%h/%h",
                 t.we, t.adr, t.dat, e.we, e.adr, e.dat);
      end
      nvec++;
      if (r.dat !== m.dat || r.err !== m.err) begin
        nerr++;
        $display("FAIL write_rsp got=%h/%b want=%h/%b", r.dat, r.err, m.dat, m.err);
      end
    end
  endtask

  task automatic test_read();
    int n = 0;
    rsp_t m;
    clear_logs();
    ready_pct = 0;
    push_cmd(1'b0, 8'h02, 8'h77, 2, 8'h3C);
    m = m_rsp(exp_q[0]);
    while (rsp_valid_o !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      nvec++;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== m.dat || rsp_err_o !== m.err) begin
        nerr++;
        $display("FAIL read_hold[%0d] got=%b/%h/%b want=1/%h/%b",
                 k, rsp_valid_o, rsp_dat_o, rsp_err_o, m.dat, m.err);
      end
      @(negedge clk_i);
    end
    ready_pct = 100;
    wait_rsp(1, 50);
    nvec++;
    if (rsp_log.size() != 1 || txn_log.size() != 1 ||
        rsp_log[0].dat !== m.dat || txn_log[0].len != m_len(exp_q[0])) begin
      nerr++;
      $display("FAIL read_rsp got=%0d rsp, %0d txn want one rsp dat=%h len=%0d",
               rsp_log.size(), txn_log.size(), m.dat, m_len(exp_q[0]));
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    exp_t e;
    rsp_t m;
    clear_logs();
    ready_pct = 0;
    push_cmd(1'b0, 8'h10, 8'h00, 0, 8'h55);
    e = exp_q[0]; m = m_rsp(e);
    while (rsp_valid_o !== 1'b1 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    repeat (2) @(negedge clk_i);
    inject = 1'b1;
    repeat (2) @(negedge clk_i);
    inject = 1'b0;
    @(negedge clk_i);
    nvec++;
    if ({rsp_valid_o, rsp_err_o, rsp_dat_o, wbif.wb_cyc_o} !== {1'b1, m.err, m.dat, 1'b0}) begin
      nerr++;
      $display("FAIL timeout_rsp got=%b/%b/%h cyc=%b want=1/%b/%h cyc=0",
               rsp_valid_o, rsp_err_o, rsp_dat_o, wbif.wb_cyc_o, m.err, m.dat);
    end
    ready_pct = 100;
    wait_rsp(1, 50);
    repeat (10) @(negedge clk_i);
    nvec++;
    if (rsp_log.size() != 1 || txn_log.size() != 1 || busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL timeout_late_ack rsp=%0d txn=%0d busy=%b want 1/1/0",
               rsp_log.size(), txn_log.size(), busy_o);
    end else begin
      nvec++;
      if (txn_log[0].len != m_len(e)) begin
        nerr++;
        $display("FAIL timeout_len got=%0d want=%0d", txn_log[0].len, m_len(e));
      end
    end
  endtask

  task automatic test_ack_timeout();
    logic [7:0] rd;
    exp_t e;
    rsp_t m;
    clear_logs();
    ready_pct = 100;
    rd = 8'($urandom_range(1, 255));
    push_cmd(1'b0, 8'h21, 8'h00, TIMEOUT, rd);
    e = exp_q[0]; m = m_rsp(e);
    wait_rsp(1, 300);
    nvec++;
    if (rsp_log.size() != 1 || txn_log.size() != 1) begin
      nerr++;
      $display("FAIL ackto_count rsp=%0d txn=%0d want 1/1", rsp_log.size(), txn_log.size());
    end else begin
      nvec++;
      if (rsp_log[0].err !== m.err || rsp_log[0].dat !== m.dat ||
          txn_log[0].len != m_len(e)) begin
        nerr++;
        $display("FAIL ackto_rsp got=%h/%b len=%0d want=%h/%b len=%0d",
                 rsp_log[0].dat, rsp_log[0].err, txn_log[0].len, m.dat, m.err, m_len(e));
      end
    end
  endtask

  task automatic test_queue();
    clear_logs();
    ready_pct = 100;
    push_cmd(1'b1, 8'h30, 8'h01, 8, 8'h00);
    for (int i = 1; i < 5; i++)
      push_cmd(1'($urandom), 8'(8'h30 + i), 8'($urandom),
               $urandom_range(1, 4), 8'($urandom));
    nvec++;
    if (cmd_ready_o !== 1'b0) begin
      nerr++;
      $display("FAIL queue_full ready=%b want 0", cmd_ready_o);
    end
    wait_rsp(5, 1000);
    nvec++;
    if (rsp_log.size() != 5 || txn_log.size() != 5) begin
      nerr++;
      $display("FAIL queue_count rsp=%0d txn=%0d want 5/5", rsp_log.size(), txn_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp_t e; rsp_t m;
        e = exp_q[i]; m = m_rsp(e);
        nvec++;
        if ({txn_log[i].we, txn_log[i].adr, txn_log[i].dat} !== {e.we, e.adr, e.dat} ||
            txn_log[i].len != m_len(e) || rsp_log[i].dat !== m.dat ||
            rsp_log[i].err !== m.err) begin
          nerr++;
          $display("FAIL queue_txn[%0d] got=%h/%h len=%0d rsp=%h/%b want=%h/%h len=%0d rsp=%h/%b",
                   i, txn_log[i].adr, txn_log[i].dat, txn_log[i].len, rsp_log[i].dat,
                   rsp_log[i].err, e.adr, e.dat, m_len(e), m.dat, m.err);
        end
        if (i > 0) begin
          nvec++;
          if (txn_log[i].gap < GAP + 1) begin
            nerr++;
            $display("FAIL queue_gap[%0d] got=%0d want>=%0d", i, txn_log[i].gap, GAP + 1);
          end
        end
      end
    end
  endtask

  task automatic test_reset_in_bus();
    int n = 0;
    clear_logs();
    ready_pct = 100;
    for (int i = 0; i < 3; i++)
      push_cmd(1'b1, 8'(8'h50 + i), 8'($urandom), 0, 8'h00);
    while (wbif.wb_cyc_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    nvec++;
    if (wbif.wb_cyc_o !== 1'b0 || wbif.wb_stb_o !== 1'b0) begin
      nerr++;
      $display("FAIL rst_bus_drop cyc=%b stb=%b want 0/0", wbif.wb_cyc_o, wbif.wb_stb_o);
    end
    repeat (2) @(negedge clk_i);
    wb_rst_i = 1'b0;
    clear_logs();
    @(negedge clk_i);
    nvec++;
    if ({busy_o, cmd_ready_o, rsp_valid_o} !== 3'b010) begin
      nerr++;
      $display("FAIL rst_bus_after busy/ready/rvalid=%b want 010",
               {busy_o, cmd_ready_o, rsp_valid_o});
    end
    push_cmd(1'b0, 8'h66, 8'h00, 3, 8'h9E);
    wait_rsp(1, 200);
    repeat (20) @(negedge clk_i);
    nvec++;
    if (txn_log.size() != 1 || rsp_log.size() != 1 ||
        txn_log[0].adr !== 8'h66 || rsp_log[0].dat !== m_rsp(exp_q[0]).dat) begin
      nerr++;
      $display("FAIL rst_bus_flush txn=%0d rsp=%0d want a single read of 66",
               txn_log.size(), rsp_log.size());
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    clear_logs();
    stab_err = 0;
    ready_pct = 60;
    for (int i = 0; i < N; i++) begin
      int ack;
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      ack = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 5);
      push_cmd(1'($urandom), 8'($urandom), 8'($urandom), ack, 8'($urandom));
    end
    wait_rsp(N, 20000);
    nvec++;
    if (rsp_log.size() != N || txn_log.size() != N) begin
      nerr++;
      $display("FAIL rand_count rsp=%0d txn=%0d want %0d", rsp_log.size(), txn_log.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        exp_t e; rsp_t m;
        e = exp_q[i]; m = m_rsp(e);
        nvec++;
        if ({txn_log[i].we, txn_log[i].adr, txn_log[i].dat} !== {e.we, e.adr, e.dat} ||
            txn_log[i].len != m_len(e) || txn_log[i].gap < GAP + 1 ||
            rsp_log[i].dat !== m.dat || rsp_log[i].err !== m.err) begin
          nerr++;
          $display("FAIL rand_txn[%0d] got=%b/%h/%h len=%0d gap=%0d rsp=%h/%b want=%b/%h/%h len=%0d rsp=%h/%b",
                   i, txn_log[i].we, txn_log[i].adr, txn_log[i].dat, txn_log[i].len,
                   txn_log[i].gap, rsp_log[i].dat, rsp_log[i].err,
                   e.we, e.adr, e.dat, m_len(e), m.dat, m.err);
        end
      end
    end
    nvec++;
    if (stab_err != 0) begin
      nerr++;
      $display("FAIL bus_stable got=%0d unstable samples want 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_timeout();
    test_queue();
    test_reset_in_bus();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
